display_arbiter: RTL

Shares the four-digit seven-segment display between two requesters with a valid/ready handshake. Generates the digit-scan timing internally and holds each accepted value on the display for a fixed number of full refresh frames before re-arbitrating round-robin. Drives active-low anodes and segments through the existing `seven_segment_data` decoder. Sits between the debug/status producers and the board display pins, replacing free-running `hex_display` scanning.

---
 rtl/display_pkg.sv | 18 +
 rtl/seven_segment_data.sv | 31 +++
 rtl/tick_divider.sv | 26 ++
 rtl/display_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the display arbiter.
package display_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } disp_state_t;

   localparam int         NUM_SRC    = 2;
   localparam logic [3:0] ANODES_OFF = 4'b1111;
   localparam logic [6:0] SEG_BLANK  = 7'b1111111;

   // Active-low one-hot anode pattern for a digit index.
   function automatic logic [3:0] idx_to_anodes(input logic [1:0] i);
      return ~(4'b0001 << i);
   endfunction

endpackage

// File: rtl/seven_segment_data.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module seven_segment_data (
   input  logic [3:0] data,
   output logic [6:0] seg
);

   // Pure lookup of the glyph for each hex digit.
   always_comb begin
      seg = 7'b1111111;
      case (data)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/tick_divider.sv
// Digit-slot prescaler: counts 0..CLK_DIV-1 and flags the last count.
module tick_divider #(
   parameter int CLK_DIV = 25000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] count;

   assign tick = (count == CW'(CLK_DIV - 1));

   // Free-running modulo-CLK_DIV counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (tick)
         count <= '0;
      else
         count <= count + CW'(1);
   end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing a 4-digit seven-segment display between two
// valid/ready requesters. Grants happen only on frame boundaries so a new
// value always starts on digit 0, and each value is held DWELL_FRAMES frames.
// Optional leading-zero blanking is enabled with the DISPLAY_LZB_EN macro.
module display_arbiter
   import display_pkg::*;
#(
   parameter int CLK_DIV      = 25000,
   parameter int DWELL_FRAMES = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   input  logic [31:0] req_data,
   output logic [1:0]  req_ready,
   output logic [3:0]  annodes,
   output logic [6:0]  seg,
   output logic        owner,
   output logic        showing
);

   localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

   logic          tick;
   logic [1:0]    idx;
   logic          fb;
   logic          window;
   logic          grant_any;
   logic          grant_src;
   disp_state_t   state, state_next;
   logic [DW-1:0] dwell, dwell_next;
   logic          pointer;
   logic [15:0]   data_latched;
   logic [3:0]    nibble;
   logic [6:0]    seg_decoded;
   logic          digit_on;

   tick_divider #(.CLK_DIV(CLK_DIV)) u_tick_divider (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   seven_segment_data u_decode (
      .data (nibble),
      .seg  (seg_decoded)
   );

   // Digit scan index advances once per digit slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         idx <= 2'd0;
      else if (tick)
         idx <= idx + 2'd1;
   end

   // Grant window and round-robin winner; ready is a single-cycle strobe.
   always_comb begin
      fb        = tick && (idx == 2'd3);
      window    = fb && ((state == IDLE) || (dwell == '0));
      grant_any = window && (|req_valid);
      grant_src = (&req_valid) ? pointer : req_valid[1];
      req_ready = 2'b00;
      if (grant_any)
         req_ready = grant_src ? 2'b10 : 2'b01;
   end

   // Next-state logic: grant restarts the dwell, expiry with no request idles.
   always_comb begin
      state_next = state;
      dwell_next = dwell;
      if (grant_any) begin
         state_next = SHOW;
         dwell_next = DW'(DWELL_FRAMES - 1);
      end else if (fb) begin
         if ((state == SHOW) && (dwell != '0))
            dwell_next = dwell - DW'(1);
         else if (window)
            state_next = IDLE;
      end
   end

   // State, dwell and grant bookkeeping registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         dwell        <= '0;
         pointer      <= 1'b0;
         owner        <= 1'b0;
         showing      <= 1'b0;
         data_latched <= 16'h0000;
      end else begin
         state <= state_next;
         dwell <= dwell_next;
         if (grant_any) begin
            pointer      <= ~grant_src;
            owner        <= grant_src;
            showing      <= 1'b1;
            data_latched <= grant_src ? req_data[31:16] : req_data[15:0];
         end
      end
   end

   // Display drive: selected nibble decoded, optionally blanking leading zeros.
   always_comb begin
      nibble   = data_latched[{idx, 2'b00} +: 4];
`ifdef DISPLAY_LZB_EN
      begin
         logic [1:0] msd;
         msd = 2'd0;
         for (int i = 1; i < 4; i++) begin
            if (data_latched[i*4 +: 4] != 4'h0)
               msd = 2'(i);
         end
         digit_on = (idx <= msd);
      end
`else
      digit_on = 1'b1;
`endif
      if (showing && digit_on) begin
         annodes = idx_to_anodes(idx);
         seg     = seg_decoded;
      end else begin
         annodes = ANODES_OFF;
         seg     = SEG_BLANK;
      end
   end

endmodule
